// File: rtl/rv32i_fetch_unit.sv
// ----------------------------------------------------------------------------
// rv32i_fetch_unit
//
// Instruction-fetch stage sitting directly in front of a registered-read
// instruction memory. Every cycle it drives the byte address the memory should
// read next. It pairs the word coming back with the address issued one cycle
// earlier, and flags that pair as valid for the IF/ID register.
//
// Stalls make the memory re-read the held word. Taken branches/jumps redirect
// the fetch and kill the wrong-path word in the same cycle. A misaligned
// redirect target latches a sticky fault that only reset clears.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   i_stall        decode cannot accept; hold the current instruction
//   i_redirect     taken branch/jump from EX; discard the current instruction
//   i_redirect_pc  redirect target
//   o_imem_addr    byte address to the instruction memory (combinational)
//   i_imem_inst    instruction memory read data (1-cycle latency)
//   o_pc           PC of the instruction on o_inst
//   o_inst         instruction to IF/ID (pass-through of i_imem_inst)
//   o_valid        o_inst/o_pc carry a real, correct-path instruction
//   o_fault        sticky misaligned-redirect fault
//   o_fault_pc     offending redirect target (0 when no fault)
//   o_fetch_cnt    number of instructions accepted by decode (wraps)
// ----------------------------------------------------------------------------
module rv32i_fetch_unit #(
    parameter int unsigned                 INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0]       RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_stall,
    input  logic                  i_redirect,
    input  logic [INST_WIDTH-1:0] i_redirect_pc,
    output logic [INST_WIDTH-1:0] o_imem_addr,
    input  logic [INST_WIDTH-1:0] i_imem_inst,
    output logic [INST_WIDTH-1:0] o_pc,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic                  o_valid,
    output logic                  o_fault,
    output logic [INST_WIDTH-1:0] o_fault_pc,
    output logic [31:0]           o_fetch_cnt
);

    localparam logic [INST_WIDTH-1:0] PcStep = INST_WIDTH'(4);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StFault
    } state_e;

    state_e                  state_q, state_d;
    logic [INST_WIDTH-1:0]   pc_q;
    logic [INST_WIDTH-1:0]   fault_pc_q, fault_pc_d;
    logic [31:0]             fetch_cnt_q, fetch_cnt_d;
    logic [INST_WIDTH-1:0]   imem_addr;
    logic                    valid;
    logic                    redirect_bad;
    logic                    redirect_ok;
    logic                    accept;

    // Redirect classification; only meaningful while in StRun.
    always_comb begin
        redirect_bad = i_redirect && (i_redirect_pc[1:0] != 2'b00);
        redirect_ok  = i_redirect && (i_redirect_pc[1:0] == 2'b00);
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   if (redirect_bad) state_d = StFault;
            StFault: state_d = StFault;
            default: state_d = StBoot;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (fetch address and valid)
    // ------------------------------------------------------------------------
    always_comb begin
        imem_addr = pc_q;
        valid     = 1'b0;
        unique case (state_q)
            StBoot: begin
                imem_addr = RESET_PC;
            end
            StRun: begin
                if (redirect_bad) begin
                    // Freeze the fetch address; the fault state holds it there.
                    imem_addr = pc_q;
                end else if (redirect_ok) begin
                    // Wrong-path word is killed in the redirect cycle itself.
                    imem_addr = i_redirect_pc;
                end else if (i_stall) begin
                    // Re-read the same word so it is still on the bus next cycle.
                    imem_addr = pc_q;
                    valid     = 1'b1;
                end else begin
                    imem_addr = pc_q + PcStep;
                    valid     = 1'b1;
                end
            end
            StFault: begin
                imem_addr = pc_q;
            end
            default: begin
                imem_addr = RESET_PC;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------------
    always_comb begin
        accept      = valid && !i_stall;
        fetch_cnt_d = accept ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
        fault_pc_d  = fault_pc_q;
        if (state_q == StRun && redirect_bad) begin
            fault_pc_d = i_redirect_pc;
        end
    end

    // pc_q is by definition the address issued last cycle, i.e. the PC of the
    // word the memory is returning now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            fault_pc_q  <= '0;
            fetch_cnt_q <= '0;
        end else begin
            pc_q        <= imem_addr;
            fault_pc_q  <= fault_pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    always_comb begin
        o_imem_addr = imem_addr;
        o_pc        = pc_q;
        o_inst      = i_imem_inst;
        o_valid     = valid;
        o_fault     = (state_q == StFault);
        o_fault_pc  = (state_q == StFault) ? fault_pc_q : '0;
        o_fetch_cnt = fetch_cnt_q;
    end

endmodule
